// File: rtl/data_memory.sv
// Data-memory responder for the M-stage port of the five-stage MIPS pipeline.
// It stores words with byte enables, has an optional fixed access latency, and logs every committed store.
module data_memory #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_write,
    input  logic        memw_enable,
    input  logic        memr_enable,
    input  logic [3:0]  byte_en,
    output logic [31:0] mem_read,
    output logic        stall,
    output logic        adr_err
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT        = 4'(LATENCY);

    // Handshake: while req is high and stall is high, the requester holds every input
    // stable. The access completes on the first rising edge where req=1 and stall=0.
    // If req drops before that edge, the access is abandoned.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [3:0]       cnt;
    logic [3:0]       cnt_next;
    state_t           state;
    logic             req;
    logic             inrange;
    logic             complete;
    logic             commit;
    logic [IDX_W-1:0] idx;
    logic [31:0]      old_word;
    logic [31:0]      merged_word;

    assign req      = memr_enable | memw_enable;
    assign inrange  = mem_adr < BYTE_LIMIT;
    assign idx      = mem_adr[IDX_W+1:2];
    assign old_word = inrange ? mem[idx] : 32'h0;
    assign mem_read = old_word;
    assign adr_err  = req & ~inrange;
    assign stall    = req & (state != DONE);
    assign complete = req & (state == DONE);
    assign commit   = complete & memw_enable & inrange & (byte_en != 4'b0000);

    // With LATENCY = 0, cnt sits at 0 and the memory is DONE straight away.
    always_comb begin
        state = IDLE;
        if (cnt == LAT)
            state = DONE;
        else if (cnt != 4'd0)
            state = WAIT;
    end

    always_comb begin
        cnt_next = 4'd0;
        if (req && !complete)
            cnt_next = cnt + 4'd1;
    end

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
                merged_word[8*i +: 8] = mem_write[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= 32'h0;
        end else begin
            cnt <= cnt_next;
            if (commit)
                mem[idx] <= merged_word;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && commit)
            $display("%d@%h: *%h <= %h", $time, M_PC, {mem_adr[31:2], 2'b00}, merged_word);
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: one instance with zero latency and one with two wait cycles.
// A word-level reference model is checked against both every cycle, alongside literal expectations.
module tb_data_memory;

    localparam int DEPTH = 3072;
    localparam int LATS [2] = '{0, 2};

    logic        clk;
    logic        rst [2];
    logic [31:0] pc  [2];
    logic [31:0] adr [2];
    logic [31:0] wd  [2];
    logic        we  [2];
    logic        re  [2];
    logic [3:0]  be  [2];
    logic [31:0] rd  [2];
    logic        st  [2];
    logic        ae  [2];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference state: word contents, and how many cycles the current request has been held.
    logic [31:0] m_mem [2][DEPTH];
    int          held  [2];

    data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .M_PC(pc[0]), .mem_adr(adr[0]), .mem_write(wd[0]),
        .memw_enable(we[0]), .memr_enable(re[0]), .byte_en(be[0]),
        .mem_read(rd[0]), .stall(st[0]), .adr_err(ae[0])
    );

    data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(rst[1]), .M_PC(pc[1]), .mem_adr(adr[1]), .mem_write(wd[1]),
        .memw_enable(we[1]), .memr_enable(re[1]), .byte_en(be[1]),
        .mem_read(rd[1]), .stall(st[1]), .adr_err(ae[1])
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] model_word(input int k, input logic [31:0] a);
        if (!in_range(a))
            return 32'h0;
        return m_mem[k][a / 4];
    endfunction

    // Model update: a request completes once it has been held for LATENCY cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                for (int w = 0; w < DEPTH; w++)
                    m_mem[k][w] = 32'h0;
                held[k] = 0;
            end else if (re[k] || we[k]) begin
                if (held[k] == LATS[k]) begin
                    if (we[k] && in_range(adr[k]) && be[k] != 4'b0) begin
                        for (int b = 0; b < 4; b++)
                            if (be[k][b])
                                m_mem[k][adr[k] / 4][8*b +: 8] = wd[k][8*b +: 8];
                    end
                    held[k] = 0;
                end else begin
                    held[k] = held[k] + 1;
                end
            end else begin
                held[k] = 0;
            end
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic req;
                req = re[k] | we[k];
                check($sformatf("model_read[%0d]", k), rd[k], model_word(k, adr[k]));
                check($sformatf("model_stall[%0d]", k), {31'b0, st[k]},
                      {31'b0, req && (held[k] != LATS[k])});
                check($sformatf("model_adr_err[%0d]", k), {31'b0, ae[k]},
                      {31'b0, req && !in_range(adr[k])});
            end
        end
    end

    // driver tasks
    task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input logic [31:0] p);
        re[k] = r; we[k] = w; adr[k] = a; wd[k] = d; be[k] = b; pc[k] = p;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0);
        end
        step();
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_en = 1;

        // ---- LATENCY = 0 instance ----
        drive(0, 1'b1, 1'b0, 32'h0000, 32'h0, 4'b0, 32'h0);
        at_neg();
        check("reset_read0", rd[0], 32'h0);
        check("reset_stall0", {31'b0, st[0]}, 32'h0);
        check("reset_err0", {31'b0, ae[0]}, 32'h0);
        step();
        drive(0, 1'b0, 1'b1, 32'h0010, 32'hDEADBEEF, 4'b1111, 32'h3000);
        step();
        drive(0, 1'b1, 1'b0, 32'h0010, 32'h0, 4'b0, 32'h3004);
        at_neg();
        check("sw_read", rd[0], 32'hDEADBEEF);
        step();
        drive(0, 1'b0, 1'b1, 32'h0011, 32'h0000AA00, 4'b0010, 32'h3008);
        step();
        drive(0, 1'b1, 1'b0, 32'h0010, 32'h0, 4'b0, 32'h300C);
        at_neg();
        check("sb_merge", rd[0], 32'hDEADAAEF);
        step();
        drive(0, 1'b0, 1'b1, 32'h3000, 32'hFFFFFFFF, 4'b1111, 32'h3010);
        at_neg();
        check("oor_err", {31'b0, ae[0]}, 32'h1);
        check("oor_read", rd[0], 32'h0);
        step();
        drive(0, 1'b1, 1'b0, 32'h0000, 32'h0, 4'b0, 32'h3014);
        at_neg();
        check("oor_no_alias", rd[0], 32'h0);
        step();
        // same-cycle read of the stored address sees the old word
        drive(0, 1'b0, 1'b1, 32'h0010, 32'h11111111, 4'b1111, 32'h3018);
        at_neg();
        check("pre_store_read", rd[0], 32'hDEADAAEF);
        step();
        drive(0, 1'b0, 1'b1, 32'h0013, 32'h99000000, 4'b0000, 32'h301C);
        step();
        drive(0, 1'b0, 1'b0, 32'h0010, 32'h0, 4'b0, 32'h0);
        at_neg();
        check("be_zero_no_write", rd[0], 32'h11111111);
        step();

        // ---- LATENCY = 2 instance ----
        drive(1, 1'b0, 1'b1, 32'h0020, 32'h12345678, 4'b1111, 32'h3100);
        at_neg();
        check("lat_stall_c1", {31'b0, st[1]}, 32'h1);
        step();
        at_neg();
        check("lat_stall_c2", {31'b0, st[1]}, 32'h1);
        step();
        at_neg();
        check("lat_stall_c3", {31'b0, st[1]}, 32'h0);
        check("lat_not_yet", rd[1], 32'h0);
        step();
        drive(1, 1'b0, 1'b0, 32'h0020, 32'h0, 4'b0, 32'h0);
        at_neg();
        check("lat_commit", rd[1], 32'h12345678);
        step();
        // abort after one cycle
        drive(1, 1'b0, 1'b1, 32'h0024, 32'hCAFEF00D, 4'b1111, 32'h3104);
        step();
        drive(1, 1'b0, 1'b0, 32'h0024, 32'h0, 4'b0, 32'h0);
        at_neg();
        check("abort_no_write", rd[1], 32'h0);
        check("abort_stall", {31'b0, st[1]}, 32'h0);
        step();
        // back-to-back: second request gets a fresh two-cycle wait
        drive(1, 1'b0, 1'b1, 32'h002C, 32'h0BADF00D, 4'b1111, 32'h3108);
        step(); step(); step();
        drive(1, 1'b1, 1'b0, 32'h002C, 32'h0, 4'b0, 32'h310C);
        at_neg();
        check("b2b_data", rd[1], 32'h0BADF00D);
        check("b2b_fresh_stall", {31'b0, st[1]}, 32'h1);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0);
        step();
        // reset in the second wait cycle, request held throughout
        drive(1, 1'b0, 1'b1, 32'h0028, 32'hA5A5A5A5, 4'b1111, 32'h3110);
        step();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        at_neg();
        check("rst_mid_stall", {31'b0, st[1]}, 32'h1);
        adr[1] = 32'h0020;
        #1;
        check("rst_mid_zeroed", rd[1], 32'h0);
        adr[1] = 32'h0028;
        step();
        at_neg();
        check("rst_restart_c2", {31'b0, st[1]}, 32'h1);
        step();
        at_neg();
        check("rst_restart_c3", {31'b0, st[1]}, 32'h0);
        step();
        drive(1, 1'b0, 1'b0, 32'h0028, 32'h0, 4'b0, 32'h0);
        at_neg();
        check("rst_restart_commit", rd[1], 32'hA5A5A5A5);

        // a few pseudo-random loads/stores on both instances, checked by the model
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 15)) * 4 + ((i % 10 == 0) ? 32'h3000 : 32'h0),
                      $urandom, 4'($urandom_range(0, 15)), 32'h4000 + 32'(i * 4));
            end
            step();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0);
        step();
        at_neg();
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
